// File: rtl/dw_win_pkg.sv
// Shared types for the 3x3 depthwise window generator.
// CH and ACT_W are fixed here; every file that handles pixels or windows
// imports these types, so retargeting the datapath width is a one-place edit.
//   act_t   : one signed activation
//   pixel_t : CH activations, channel c at [c*ACT_W +: ACT_W]
//   win_t   : CH x TAPS activations, channel c tap k at [c*9*ACT_W + k*ACT_W +: ACT_W]
//   wreg_t  : window registers indexed [row][col], row 0 = top, col 0 = left
// pack_win() maps the [row][col] register view onto the win_t output layout.
package dw_win_pkg;

  localparam int TAPS  = 9;
  localparam int CH    = 8;
  localparam int ACT_W = 16;

  typedef logic signed [ACT_W-1:0] act_t;
  typedef act_t [CH-1:0]           pixel_t;
  typedef act_t [CH-1:0][TAPS-1:0] win_t;
  typedef pixel_t [2:0][2:0]       wreg_t;

  function automatic win_t pack_win(input wreg_t w);
    win_t p;
    p = '0;
    for (int c = 0; c < CH; c++) begin
      for (int r = 0; r < 3; r++) begin
        for (int x = 0; x < 3; x++) begin
          p[c][3*r+x] = w[r][x][c];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/dw_win_line_buf.sv
// One-row delay line for the window generator.
// A beat at column addr_i returns the pixel stored at that column one row
// ago and overwrites it with wdata_i in the same cycle.
// Ports:
//   clk, rstn   clock, async active-low reset (memory cleared)
//   we_i        accepted beat
//   addr_i      current column
//   wdata_i     pixel to store
//   rdata_o     pixel previously stored at addr_i (combinational read)
module dw_win_line_buf
  import dw_win_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  pixel_t        wdata_i,
  output pixel_t        rdata_o
);

  pixel_t mem_q [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dw_window_gen.sv
// Streaming 3x3 sliding-window generator feeding the depthwise-conv stage.
// Takes one CH-channel pixel per beat in raster order, keeps the two previous
// rows in line buffers, and presents a full 3x3 window ("valid" padding,
// stride 1) one clock after the beat that completes it.
// Build option: DW_WIN_STRIDE2_EN -- only windows whose bottom-right pixel
// sits on an even row and even column are flagged (stride-2 decimation).
// Ports:
//   clk, rstn   clock, async active-low reset
//   in_valid    in_pixel carries a pixel this cycle (no backpressure)
//   in_sof      with in_valid: this pixel is (row 0, col 0)
//   in_pixel    channel c at [c*ACT_W +: ACT_W]
//   win_valid   1-cycle pulse: win_act holds a complete window
//   win_act     channel c, tap k at [c*9*ACT_W + k*ACT_W +: ACT_W], k = 3*row + col
//   frame_done  1-cycle pulse after the last pixel of a frame
//   sof_err     1-cycle pulse: in_sof arrived while not at (0,0)
module dw_window_gen
  import dw_win_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic [CH*ACT_W-1:0]       in_pixel,
  output logic                      win_valid,
  output logic [CH*TAPS*ACT_W-1:0]  win_act,
  output logic                      frame_done,
  output logic                      sof_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          sof_err_q, sof_err_d;
  logic          last_px, win_hit;
  wreg_t         w_q, w_d;
  pixel_t        pix_in, top_px, mid_px;

  assign pix_in = pixel_t'(in_pixel);

  // in_sof overrides the counters so the sof pixel itself lands at (0,0).
  assign col_eff = in_sof ? '0 : col_q;
  assign row_eff = in_sof ? '0 : row_q;
  assign last_px = (row_eff == RW'(IMG_H-1)) && (col_eff == CW'(IMG_W-1));

`ifdef DW_WIN_STRIDE2_EN
  assign win_hit = (row_eff >= RW'(2)) && (col_eff >= CW'(2)) && !row_eff[0] && !col_eff[0];
`else
  assign win_hit = (row_eff >= RW'(2)) && (col_eff >= CW'(2));
`endif

  // lb0 holds row-2, lb1 holds row-1; lb1's old entry ages into lb0.
  dw_win_line_buf #(.DEPTH(IMG_W)) u_lb0 (
    .clk     (clk),
    .rstn    (rstn),
    .we_i    (in_valid),
    .addr_i  (col_eff),
    .wdata_i (mid_px),
    .rdata_o (top_px)
  );

  dw_win_line_buf #(.DEPTH(IMG_W)) u_lb1 (
    .clk     (clk),
    .rstn    (rstn),
    .we_i    (in_valid),
    .addr_i  (col_eff),
    .wdata_i (pix_in),
    .rdata_o (mid_px)
  );

  always_comb begin
    w_d          = w_q;
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    sof_err_d    = 1'b0;
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        w_d[r][0] = w_q[r][1];
        w_d[r][1] = w_q[r][2];
      end
      w_d[0][2]   = top_px;
      w_d[1][2]   = mid_px;
      w_d[2][2]   = pix_in;
      win_valid_d = win_hit;
      sof_err_d   = in_sof && ((row_q != '0) || (col_q != '0));
      if (last_px) begin
        col_d        = '0;
        row_d        = '0;
        frame_done_d = 1'b1;
      end else if (col_eff == CW'(IMG_W-1)) begin
        col_d = '0;
        row_d = row_eff + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_q          <= '0;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      w_q          <= w_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
    end
  end

  // Window regs only move on beats, so win_act is stable between them.
  assign win_act    = pack_win(w_q);
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;

endmodule

// File: tb/tb_dw_window_gen.sv
module tb_dw_window_gen;
  import dw_win_pkg::*;

  localparam int W = 8;
  localparam int H = 8;
`ifdef DW_WIN_STRIDE2_EN
  localparam int NW = 9;
  localparam int NW_ABORT = 3 + 9;
`else
  localparam int NW = 36;
  localparam int NW_ABORT = 9 + 36;
`endif

  logic                     clk = 1'b0;
  logic                     rstn;
  logic                     in_valid;
  logic                     in_sof;
  logic [CH*ACT_W-1:0]      in_pixel;
  logic                     win_valid;
  logic [CH*TAPS*ACT_W-1:0] win_act;
  logic                     frame_done;
  logic                     sof_err;

  dw_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_pixel   (in_pixel),
    .win_valid  (win_valid),
    .win_act    (win_act),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  always #5 clk = ~clk;

  int   vec  = 0;
  int   errs = 0;
  win_t exp_q[$];
  win_t got_list[$];
  int   got_win = 0;
  int   got_fd  = 0;
  int   got_se  = 0;

  // Pixel (r,x) channel c = c*256 + r*16 + x, plus frame index in bits 15:12.
  function automatic pixel_t pix(int f, int r, int x);
    pixel_t p;
    for (int c = 0; c < CH; c++) p[c] = act_t'(f*4096 + c*256 + r*16 + x);
    return p;
  endfunction

  function automatic win_t exp_win(int f, int r, int x);
    win_t   w;
    pixel_t p;
    for (int rr = 0; rr < 3; rr++) begin
      for (int cc = 0; cc < 3; cc++) begin
        p = pix(f, r-2+rr, x-2+cc);
        for (int c = 0; c < CH; c++) w[c][3*rr+cc] = p[c];
      end
    end
    return w;
  endfunction

  function automatic bit emits(int r, int x);
`ifdef DW_WIN_STRIDE2_EN
    return (r >= 2) && (x >= 2) && (r % 2 == 0) && (x % 2 == 0);
`else
    return (r >= 2) && (x >= 2);
`endif
  endfunction

  task automatic chk(string name, int got, int expv);
    vec++;
    if (got != expv) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic beat(pixel_t p, logic sof);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_sof   = sof;
    in_pixel = p;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  // Sends frame f in raster order, stopping before (stop_r, stop_x) if given.
  task automatic send_frame(int f, int gap_pct, int stop_r, int stop_x, bit sof_first);
    for (int r = 0; r < H; r++) begin
      for (int x = 0; x < W; x++) begin
        if (r == stop_r && x == stop_x) return;
        while ($urandom_range(99) < gap_pct) idle(1);
        beat(pix(f, r, x), sof_first && r == 0 && x == 0);
        if (emits(r, x)) exp_q.push_back(exp_win(f, r, x));
      end
    end
  endtask

  task automatic clear_counts();
    got_win = 0;
    got_fd  = 0;
    got_se  = 0;
    got_list.delete();
  endtask

  // Monitor: scoreboard pop on win_valid, pulse counting, and win_act stability
  // across cycles with no accepted beat.
  logic prev_valid = 1'b0;
  logic prev_rstn  = 1'b0;
  logic [CH*TAPS*ACT_W-1:0] prev_act = '0;

  always @(negedge clk) begin
    win_t e, g;
    if (rstn && prev_rstn && !prev_valid) begin
      vec++;
      if (win_act !== prev_act) begin
        errs++;
        $display("FAIL act_stable: win_act changed without a beat at %0t", $time);
      end
    end
    if (win_valid) begin
      g = win_t'(win_act);
      got_list.push_back(g);
      got_win++;
      vec++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL win_unexpected: window at %0t, none expected", $time);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          errs++;
          for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < TAPS; k++) begin
              if (g[c][k] !== e[c][k]) begin
                $display("FAIL win_data: ch%0d tap%0d got %h expected %h at %0t",
                         c, k, g[c][k], e[c][k], $time);
                c = CH;
                break;
              end
            end
          end
        end
      end
    end
    if (frame_done) got_fd++;
    if (sof_err) got_se++;
    prev_act   = win_act;
    prev_valid = in_valid;
    prev_rstn  = rstn;
  end

  initial begin
    win_t w;
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_sof_err", int'(sof_err), 0);
    chk("rst_win_act_zero", int'(win_act == '0), 1);
    rstn = 1'b1;
    idle(2);

    // 1: continuous frame
    clear_counts();
    send_frame(0, 0, -1, -1, 1'b1);
    idle(3);
    chk("f0_windows", got_win, NW);
    chk("f0_frame_done", got_fd, 1);
    chk("f0_sof_err", got_se, 0);
    chk("f0_queue_left", exp_q.size(), 0);
    if (got_list.size() >= 2) begin
      w = got_list[0];
      chk("f0_w0_ch0_tap0", int'(w[0][0]), 'h0000);
      chk("f0_w0_ch0_tap4", int'(w[0][4]), 'h0011);
      chk("f0_w0_ch0_tap8", int'(w[0][8]), 'h0022);
      chk("f0_w0_ch7_tap8", int'(w[7][8]), 'h0722);
      w = got_list[1];
`ifdef DW_WIN_STRIDE2_EN
      chk("f0_w1_ch0_tap8", int'(w[0][8]), 'h0024);
`else
      chk("f0_w1_ch0_tap8", int'(w[0][8]), 'h0023);
`endif
    end else begin
      chk("f0_window_list", got_list.size(), 2);
    end

    // 2: ~50% bubbles
    clear_counts();
    send_frame(1, 50, -1, -1, 1'b1);
    idle(3);
    chk("gap_windows", got_win, NW);
    chk("gap_frame_done", got_fd, 1);
    chk("gap_queue_left", exp_q.size(), 0);

    // 3: sof arrives at (3,5), abandoning frame 2
    clear_counts();
    send_frame(2, 0, 3, 5, 1'b1);
    send_frame(3, 0, -1, -1, 1'b1);
    idle(3);
    chk("abort_sof_err", got_se, 1);
    chk("abort_frame_done", got_fd, 1);
    chk("abort_windows", got_win, NW_ABORT);
    chk("abort_queue_left", exp_q.size(), 0);

    // 4: reset at (4,4), then a frame without sof
    send_frame(4, 0, 4, 4, 1'b1);
    idle(3);
    @(posedge clk); #1;
    rstn = 1'b0;
    idle(2);
    chk("mid_rst_win_valid", int'(win_valid), 0);
    chk("mid_rst_win_act_zero", int'(win_act == '0), 1);
    rstn = 1'b1;
    idle(1);
    clear_counts();
    send_frame(5, 0, -1, -1, 1'b0);
    idle(3);
    chk("post_rst_windows", got_win, NW);
    chk("post_rst_frame_done", got_fd, 1);
    chk("post_rst_queue_left", exp_q.size(), 0);

    // 5: back-to-back frames
    clear_counts();
    send_frame(6, 0, -1, -1, 1'b1);
    send_frame(7, 0, -1, -1, 1'b1);
    idle(3);
    chk("b2b_windows", got_win, 2*NW);
    chk("b2b_frame_done", got_fd, 2);
    chk("b2b_sof_err", got_se, 0);
    chk("b2b_queue_left", exp_q.size(), 0);
    if (got_list.size() > NW) begin
      w = got_list[NW];
      chk("b2b_f2_tap0", int'(w[0][0]), 'h7000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
